// File: rtl/data_mem_mmio.sv
// Data-memory responder: word RAM plus an MMIO window holding a TX FIFO feeding
// an 8N1 serial transmitter, a status register and a free-running cycle counter.
module data_mem_mmio #(
   parameter int MEM_DEPTH  = 1024,
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD_DIV   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ram_raddr,
   output logic [31:0] ram_rdata,
   input  logic [31:0] ram_waddr,
   input  logic [31:0] ram_wdata,
   input  logic        ram_we,
   output logic        tx_out,
   output logic        tx_busy
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(BAUD_DIV);

   localparam logic [31:0] MEM_LIMIT   = 32'(MEM_DEPTH);
   localparam logic [31:0] ADDR_TX     = 32'h8000_0000;
   localparam logic [31:0] ADDR_STATUS = 32'h8000_0001;
   localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0002;
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

   logic [31:0]   mem [MEM_DEPTH];
   logic [7:0]    fifo_mem [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   cycle_q, cycle_d;

   tx_state_t     state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_out_q;

   logic          wr_ram, wr_tx, wr_status, wr_cycle;
   logic          full, empty, pop, push_ok, baud_end;
   logic [3:0]    count4;

   assign wr_ram    = ram_we && (ram_waddr < MEM_LIMIT);
   assign wr_tx     = ram_we && (ram_waddr == ADDR_TX);
   assign wr_status = ram_we && (ram_waddr == ADDR_STATUS);
   assign wr_cycle  = ram_we && (ram_waddr == ADDR_CYCLE);

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign pop      = (state_q == S_IDLE) && !empty;
   assign push_ok  = wr_tx && (!full || pop);
   assign baud_end = (baud_q == BAUD_LAST);

   assign tx_out  = tx_out_q;
   assign tx_busy = (state_q != S_IDLE);

   generate
      if (CW >= 4) begin : g_cnt_trunc
         assign count4 = count_q[3:0];
      end else begin : g_cnt_ext
         assign count4 = {{(4 - CW){1'b0}}, count_q};
      end
   endgenerate

   always_comb begin
      ram_rdata = '0;
      if (ram_raddr < MEM_LIMIT) begin
         ram_rdata = mem[ram_raddr[AW-1:0]];
      end else if (ram_raddr == ADDR_STATUS) begin
         ram_rdata = {24'b0, count4, overflow_q, tx_busy, full, empty};
      end else if (ram_raddr == ADDR_CYCLE) begin
         ram_rdata = cycle_q;
      end
   end

   // RAM has no reset and keeps accepting writes while rst_n is low.
   always_ff @(posedge clk) begin
      if (wr_ram) begin
         mem[ram_waddr[AW-1:0]] <= ram_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_ok) begin
         fifo_mem[wr_ptr_q] <= ram_wdata[7:0];
      end
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      cycle_d    = wr_cycle ? ram_wdata : cycle_q + 32'd1;
      if (wr_status) begin
         overflow_d = 1'b0;
      end
      // A dropped push outranks a same-cycle clear.
      if (wr_tx && !push_ok) begin
         overflow_d = 1'b1;
      end
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push_ok && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push_ok && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         cycle_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         cycle_q    <= cycle_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_out_q <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_out_q <= 1'b1;
               baud_q   <= '0;
               if (pop) begin
                  shift_q  <= fifo_mem[rd_ptr_q];
                  tx_out_q <= 1'b0;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (baud_end) begin
                  baud_q   <= '0;
                  bit_q    <= '0;
                  tx_out_q <= shift_q[0];
                  shift_q  <= {1'b0, shift_q[7:1]};
                  state_q  <= S_DATA;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_out_q <= 1'b1;
                     state_q  <= S_STOP;
                  end else begin
                     bit_q    <= bit_q + 3'd1;
                     tx_out_q <= shift_q[0];
                     shift_q  <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            S_STOP: begin
               tx_out_q <= 1'b1;
               if (baud_end) begin
                  baud_q  <= '0;
                  state_q <= S_IDLE;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            default: begin
               state_q  <= S_IDLE;
               tx_out_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench: a BAUD_DIV=4 instance for bit timing and a BAUD_DIV=16 instance
// for FIFO/overflow, cycle counter and reset tests; both share the bus inputs.
module tb_data_mem_mmio;

   localparam logic [31:0] A_TX     = 32'h8000_0000;
   localparam logic [31:0] A_STATUS = 32'h8000_0001;
   localparam logic [31:0] A_CYCLE  = 32'h8000_0002;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ram_raddr, ram_waddr, ram_wdata;
   logic        ram_we;
   logic [31:0] rdata4, rdata16;
   logic        tx4, busy4, tx16, busy16;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic prev_busy = 1'b0;
   logic txh [0:8191];
   int rises[$];

   always #5 clk = ~clk;

   data_mem_mmio #(.MEM_DEPTH(1024), .FIFO_DEPTH(8), .BAUD_DIV(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .ram_raddr(ram_raddr), .ram_rdata(rdata4),
      .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .tx_out(tx4), .tx_busy(busy4)
   );

   data_mem_mmio #(.MEM_DEPTH(1024), .FIFO_DEPTH(8), .BAUD_DIV(16)) u16 (
      .clk(clk), .rst_n(rst_n),
      .ram_raddr(ram_raddr), .ram_rdata(rdata16),
      .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .tx_out(tx16), .tx_busy(busy16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One edge; also logs the 16-divider line and its frame starts.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 8192) txh[cyc] = tx16;
      if (busy16 && !prev_busy) rises.push_back(cyc);
      prev_busy = busy16;
   endtask

   task automatic rd(input logic [31:0] a);
      ram_raddr = a;
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      ram_we    = 1'b1;
      ram_waddr = a;
      ram_wdata = d;
      tick();
      ram_we    = 1'b0;
   endtask

   initial begin
      logic [9:0] a5_frame;
      logic [7:0] b;
      int busy_n, bad, r;

      rst_n = 1'b0; ram_we = 1'b0; ram_waddr = '0; ram_wdata = '0; ram_raddr = '0;
      repeat (3) tick();
      rd(A_STATUS);
      chk("rst_status16", rdata16, 32'h1);
      chk("rst_status4", rdata4, 32'h1);
      chk("rst_tx_out", {31'b0, tx16}, 32'h1);
      chk("rst_tx_busy", {31'b0, busy16}, 32'h0);
      rst_n = 1'b1;
      repeat (5) tick();
      rd(A_CYCLE);
      chk("cycle_after_5", rdata16, 32'd5);

      // RAM read-during-write and out-of-range address
      wr(32'd3, 32'h1111_1111);
      ram_we = 1'b1; ram_waddr = 32'd3; ram_wdata = 32'hDEAD_BEEF;
      rd(32'd3);
      chk("rdw_old", rdata16, 32'h1111_1111);
      tick();
      ram_we = 1'b0;
      rd(32'd3);
      chk("rdw_new", rdata16, 32'hDEAD_BEEF);
      wr(32'd1024, 32'h1234_5678);
      rd(32'd1024);
      chk("oob_read", rdata16, 32'h0);
      rd(32'd0);
      chk("oob_no_alias", rdata16 === 32'h1234_5678 ? 32'h1 : 32'h0, 32'h0);
      rd(32'd3);
      chk("ram3_kept", rdata16, 32'hDEAD_BEEF);
      rd(A_TX);
      chk("txdata_read", rdata16, 32'h0);

      // 0xA5 on the BAUD_DIV=4 instance: {stop, A5, start}, slot 0 in bit 0
      a5_frame = 10'b1_1010_0101_0;
      wr(A_TX, 32'h0000_00A5);
      rd(A_STATUS);
      chk("a5_status", rdata4, 32'h10);
      busy_n = 0;
      for (int i = 0; i < 44; i++) begin
         tick();
         if (busy4) busy_n++;
         chk($sformatf("a5_tx_cyc%0d", i), {31'b0, tx4}, (i < 40) ? {31'b0, a5_frame[i/4]} : 32'h1);
      end
      chk("a5_busy_cycles", busy_n, 32'd40);

      // Fill FIFO of BAUD_DIV=16 instance
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      rises.delete();
      for (int i = 0; i < 9; i++) begin
         wr(A_TX, 32'(i + 1));
         rd(A_STATUS);
         chk($sformatf("fill_count%0d", i), {28'b0, rdata16[7:4]}, (i == 0) ? 32'd1 : 32'(i));
      end
      rd(A_STATUS);
      chk("fill_status", rdata16, 32'h86);
      wr(A_TX, 32'h0000_00EE);
      rd(A_STATUS);
      chk("ovf_set", rdata16, 32'h8E);
      wr(A_STATUS, 32'h0);
      rd(A_STATUS);
      chk("ovf_clear", rdata16, 32'h86);
      repeat (9 * 161 + 40) tick();
      chk("frame_count", rises.size(), 32'd9);
      for (int f = 0; f < rises.size() && f < 9; f++) begin
         r = rises[f];
         for (int k = 0; k < 8; k++) b[k] = txh[r + 16 * (k + 1) + 8];
         chk($sformatf("frame%0d_start", f), {31'b0, txh[r + 8]}, 32'h0);
         chk($sformatf("frame%0d_byte", f), {24'b0, b}, 32'(f + 1));
         chk($sformatf("frame%0d_stop", f), {31'b0, txh[r + 152]}, 32'h1);
         if (f > 0) chk($sformatf("frame%0d_period", f), r - rises[f-1], 32'd161);
      end

      // Cycle counter load and wrap
      wr(A_CYCLE, 32'hFFFF_FFFE);
      rd(A_CYCLE);
      chk("cycle_load", rdata16, 32'hFFFF_FFFE);
      tick();
      chk("cycle_max", rdata16, 32'hFFFF_FFFF);
      tick();
      chk("cycle_wrap", rdata16, 32'h0);

      // Reset during data bit 3 (0x52 bit3 = 0)
      wr(32'd5, 32'hCAFE_F00D);
      wr(A_TX, 32'h0000_0052);
      repeat (70) tick();
      chk("mid_busy", {31'b0, busy16}, 32'h1);
      chk("mid_bit3", {31'b0, tx16}, 32'h0);
      rst_n = 1'b0;
      ram_we = 1'b1; ram_waddr = A_TX; ram_wdata = 32'h77;
      tick();
      rd(A_STATUS);
      chk("abort_tx_out", {31'b0, tx16}, 32'h1);
      chk("abort_busy", {31'b0, busy16}, 32'h0);
      chk("abort_status", rdata16, 32'h1);
      ram_waddr = 32'd7; ram_wdata = 32'h0BAD_CAFE;
      tick();
      ram_we = 1'b0;
      rst_n = 1'b1;
      bad = 0;
      repeat (200) begin
         tick();
         if (!tx16 || busy16) bad++;
      end
      chk("no_frame_after_reset", bad, 32'd0);
      rd(32'd5);
      chk("ram5_kept", rdata16, 32'hCAFE_F00D);
      rd(32'd7);
      chk("ram7_reset_write", rdata16, 32'h0BAD_CAFE);
      rd(A_STATUS);
      chk("post_reset_status", rdata16, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Responder for the core's data-memory port. It serves `ram_raddr`/`ram_rdata` reads combinationally within the core's single cycle and commits `ram_waddr`/`ram_wdata`/`ram_we` writes on the clock edge. It backs a word-addressed RAM and a small memory-mapped I/O window: a transmit FIFO feeding an 8N1 serial transmitter, a status register and a free-running cycle counter. It sits beside the core at top level, on the far end of the core's `ram_*` ports.

## Interface
- `MEM_DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `BAUD_DIV`, 16: clocks per serial bit; ≥2.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ram_raddr`  in  32  word read address.
- `ram_rdata`  out  32  read data, combinational from `ram_raddr` and current state.
- `ram_waddr`  in  32  word write address.
- `ram_wdata`  in  32  write data.
- `ram_we`  in  1  write enable, sampled on rising edge.
- `tx_out`  out  1  serial line, idle high.
- `tx_busy`  out  1  transmitter not IDLE.

## Operation
- Address map (word addresses):
  - RAM: `addr < MEM_DEPTH`. Read returns word. Write stores word.
  - TX_DATA: `0x8000_0000`. Write pushes `wdata[7:0]`. Read returns 0.
  - STATUS: `0x8000_0001`. Read returns `{24'b0, count[3:0], overflow, tx_busy, full, empty}`, with `count` zero-extended or truncated to 4 bits. Any write clears `overflow`.
  - CYCLE: `0x8000_0002`. Read returns counter. Write loads `wdata`.
  - All other addresses: read 0, write ignored.
- RAM is not cleared by reset. Contents persist across `rst_n`.
- Read-during-write to the same address returns the old value. The write takes effect at the edge.
- FIFO push:
  - Accepted when not full, or when a pop occurs in the same cycle.
  - Otherwise data is dropped and sticky `overflow` is set.
  - If a STATUS write and an overflow happen in the same cycle, `overflow` ends at 1.
- CYCLE counter increments by 1 every cycle and wraps `0xFFFF_FFFF` → 0. A write in the same cycle wins: the counter takes `wdata`.
- TX FSM, with an internal bit counter and baud counter:
  - IDLE: `tx_out=1`. If FIFO not empty, pop into the shift register and go to START.
  - START: `tx_out=0` for `BAUD_DIV` cycles, then DATA.
  - DATA: 8 bits, LSB first, each held `BAUD_DIV` cycles, then STOP.
  - STOP: `tx_out=1` for `BAUD_DIV` cycles, then IDLE.
- `tx_busy = (state != IDLE)`. It is registered-state derived, with no combinational path from `ram_*`.
- `tx_out` is driven directly from a register.

## Timing
- Reset values:
  - `tx_out=1`, `tx_busy=0`, state IDLE.
  - FIFO empty, count 0, `overflow=0`, CYCLE=0.
  - `ram_rdata` stays combinational during reset, so STATUS reads `0x1` while `rst_n=0`.
- Reset asserted mid-frame aborts the frame, empties the FIFO and forces `tx_out=1` at that edge. `ram_we` during reset writes RAM but not MMIO.
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- TX_DATA write at edge N on an empty FIFO in IDLE:
  - Count is 1 after N.
  - Pop at edge N+1: `tx_out` falls and `tx_busy` rises after N+1.
  - Start bit spans N+1..N+BAUD_DIV. Bit k occupies the `BAUD_DIV` cycles starting at edge N+1+(k+1)·BAUD_DIV.
  - Stop ends and IDLE is re-entered at edge N+1+10·BAUD_DIV.
- Back-to-back frames: IDLE lasts exactly 1 cycle between frames, so frame period is `10·BAUD_DIV+1` cycles.
- Full: count==FIFO_DEPTH. Empty: count==0. Pointers wrap modulo FIFO_DEPTH.

## Test plan
- Reset, then read STATUS → `0x0000_0001`. `tx_out=1`, `tx_busy=0`. Read CYCLE five cycles after release → 5 (±0 relative to the release edge, counter 0 at the first post-reset edge).
- Write `0xDEADBEEF` to RAM addr 3. Same-cycle read of addr 3 returns old data, next cycle returns `0xDEADBEEF`. Write to addr `MEM_DEPTH` is ignored, and reading it returns 0.
- `BAUD_DIV=4`, write `0xA5` to TX_DATA:
  - `tx_out` sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1 starting 1 cycle after the write.
  - `tx_busy` is high for exactly 40 cycles.
- Write 9 bytes in consecutive cycles with `FIFO_DEPTH=8`, `BAUD_DIV=16`:
  - The first byte is popped at the 2nd edge, so all 9 are accepted and `overflow=0`.
  - A 10th write while full sets `overflow=1`, and STATUS bit3 reads 1.
  - A STATUS write clears it.
  - Nine frames are emitted, each 161 cycles apart.
- Write `0xFFFF_FFFE` to CYCLE: reads `0xFFFF_FFFF` one cycle later, then 0.
- Assert `rst_n=0` mid-DATA bit 3: `tx_out=1`, `tx_busy=0`, STATUS=`0x1` after the edge. No further frame bits appear, and the previously written RAM word is unchanged.
